// File: rtl/controller_pkg.sv
// controller_pkg: opcode/funct/ALU encodings and scoreboard/ID-EX record types
package controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRA  = 4'd1;
    localparam logic [3:0] ALU_SRL  = 4'd2;
    localparam logic [3:0] ALU_ADD  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_SLT  = 4'd11;
    localparam logic [3:0] ALU_SLTU = 4'd12;

    typedef struct packed {
        logic       wr_en;
        logic [4:0] wr_addr;
        logic       is_load;
    } sb_entry_t;

    localparam int SB_W = $bits(sb_entry_t);

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic [3:0] aluop;
        logic       dmload;
        logic       dmstr;
        logic       dmsel;
        logic       regwrite;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] rw;
    } ex_ctrl_t;

endpackage

// File: rtl/pipelined_controller_fwd_scoreboard.sv
// fwd_scoreboard: shifting history of in-flight destinations with youngest-first operand match
module fwd_scoreboard
    import controller_pkg::*;
#(
    parameter int FWD_DEPTH = 3,
    localparam int FSW = $clog2(FWD_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_wr_en,
    input  logic [4:0]     push_wr_addr,
    input  logic           push_is_load,
    input  logic           valid,
    input  logic [4:0]     ra,
    input  logic [4:0]     rb,
    input  logic           uses_a,
    input  logic           uses_b,
    output logic [FSW-1:0] fwd_a,
    output logic [FSW-1:0] fwd_b,
    output logic           load_hazard
);

    sb_entry_t [FWD_DEPTH-1:0] ent_q, ent_d;
    logic unused_sb;

    assign unused_sb = ^ent_q;

    always_comb begin
        ent_d[0] = {push_wr_en, push_wr_addr, push_is_load};
        for (int i = 1; i < FWD_DEPTH; i++) ent_d[i] = ent_q[i-1];
    end

    // Walk oldest to youngest so the youngest match overwrites.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (uses_a && ra != 5'd0 && ent_q[k].wr_en && ent_q[k].wr_addr == ra) fwd_a = FSW'(k + 1);
            if (uses_b && rb != 5'd0 && ent_q[k].wr_en && ent_q[k].wr_addr == rb) fwd_b = FSW'(k + 1);
        end
    end

    assign load_hazard = valid && ent_q[0].is_load && ent_q[0].wr_addr != 5'd0 &&
                         ((uses_a && ra == ent_q[0].wr_addr) || (uses_b && rb == ent_q[0].wr_addr));

    always_ff @(posedge clk) begin
        if (rst) ent_q <= '0;
        else     ent_q <= ent_d;
    end

endmodule

// File: rtl/pipelined_controller.sv
// pipelined_controller: registered MIPS decode stage with forwarding selects and load-use stall
module pipelined_controller
    import controller_pkg::*;
#(
    parameter int FWD_DEPTH = 3,
    parameter int DATA_W = 32,
    localparam int FSW = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] IR,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              ex_valid,
    output logic [3:0]        ex_aluop,
    output logic              ex_dmload,
    output logic              ex_dmstr,
    output logic              ex_dmsel,
    output logic              ex_regwrite,
    output logic [4:0]        ex_ra,
    output logic [4:0]        ex_rb,
    output logic [4:0]        ex_rw,
    output logic [DATA_W-1:0] ex_imm,
    output logic [FSW-1:0]    ex_fwd_a,
    output logic [FSW-1:0]    ex_fwd_b,
    output logic              ex_illegal
);

    logic [3:0]        aluop;
    logic              regwrite, dmload, dmstr, dmsel, zext, rtype, jal, uses_a, uses_b, illegal;
    logic              wr_en, load_hazard, issue, unused_bits;
    logic [4:0]        ra, rb, rw;
    logic [DATA_W-1:0] imm;
    logic [FSW-1:0]    fwd_a, fwd_b;
    ex_ctrl_t          ex_q, ex_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [FSW-1:0]    fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    assign unused_bits = ^IR[10:6];

    always_comb begin
        aluop    = '0;
        regwrite = 1'b0;
        dmload   = 1'b0;
        dmstr    = 1'b0;
        dmsel    = 1'b0;
        zext     = 1'b0;
        rtype    = 1'b0;
        jal      = 1'b0;
        uses_a   = 1'b1;
        uses_b   = 1'b0;
        illegal  = 1'b0;
        case (IR[31:26])
            OP_RTYPE: begin
                rtype    = 1'b1;
                regwrite = 1'b1;
                uses_b   = 1'b1;
                case (IR[5:0])
                    F_SLL:          begin aluop = ALU_SLL; uses_a = 1'b0; end
                    F_SRL:          begin aluop = ALU_SRL; uses_a = 1'b0; end
                    F_SRA:          begin aluop = ALU_SRA; uses_a = 1'b0; end
                    F_ADD, F_ADDU:  aluop = ALU_ADD;
                    F_SUB, F_SUBU:  aluop = ALU_SUB;
                    F_AND:          aluop = ALU_AND;
                    F_OR:           aluop = ALU_OR;
                    F_XOR:          aluop = ALU_XOR;
                    F_NOR:          aluop = ALU_NOR;
                    F_SLT:          aluop = ALU_SLT;
                    F_SLTU:         aluop = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            OP_J:              uses_a = 1'b0;
            OP_JAL:            begin uses_a = 1'b0; regwrite = 1'b1; jal = 1'b1; aluop = ALU_ADD; end
            OP_BEQ, OP_BNE:    begin aluop = ALU_SUB; uses_b = 1'b1; end
            OP_ADDI, OP_ADDIU: begin aluop = ALU_ADD; regwrite = 1'b1; end
            OP_SLTI:           begin aluop = ALU_SLT; regwrite = 1'b1; end
            OP_SLTIU:          begin aluop = ALU_SLTU; regwrite = 1'b1; end
            OP_ANDI:           begin aluop = ALU_AND; regwrite = 1'b1; zext = 1'b1; end
            OP_ORI:            begin aluop = ALU_OR; regwrite = 1'b1; zext = 1'b1; end
            OP_XORI:           begin aluop = ALU_XOR; regwrite = 1'b1; zext = 1'b1; end
            OP_LW:             begin aluop = ALU_ADD; regwrite = 1'b1; dmload = 1'b1; end
            OP_LBU:            begin aluop = ALU_ADD; regwrite = 1'b1; dmload = 1'b1; dmsel = 1'b1; end
            OP_SW:             begin aluop = ALU_ADD; dmstr = 1'b1; uses_b = 1'b1; end
            default:           illegal = 1'b1;
        endcase
    end

    assign ra     = IR[25:21];
    assign rb     = IR[20:16];
    assign rw     = rtype ? IR[15:11] : jal ? 5'd31 : IR[20:16];
    assign imm    = {{(DATA_W-16){IR[15] & ~zext}}, IR[15:0]};
    assign wr_en  = regwrite & ~illegal;

    // Flush outranks the stall, so a flushed hazard still accepts (and drops) IR.
    assign in_ready = ~(load_hazard & ~flush);
    assign issue    = in_valid & ~flush & ~load_hazard;

    fwd_scoreboard #(.FWD_DEPTH(FWD_DEPTH)) u_sb (
        .clk          (clk),
        .rst          (rst),
        .push_wr_en   (issue & wr_en),
        .push_wr_addr (issue ? rw : 5'd0),
        .push_is_load (issue & dmload & ~illegal),
        .valid        (in_valid),
        .ra           (ra),
        .rb           (rb),
        .uses_a       (uses_a),
        .uses_b       (uses_b),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .load_hazard  (load_hazard)
    );

    always_comb begin
        ex_d    = '0;
        imm_d   = '0;
        fwd_a_d = '0;
        fwd_b_d = '0;
        if (issue) begin
            ex_d    = '{valid: 1'b1, illegal: illegal, aluop: aluop,
                        dmload: dmload & ~illegal, dmstr: dmstr & ~illegal, dmsel: dmsel,
                        regwrite: wr_en, ra: ra, rb: rb, rw: rw};
            imm_d   = imm;
            fwd_a_d = fwd_a;
            fwd_b_d = fwd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            imm_q   <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else begin
            ex_q    <= ex_d;
            imm_q   <= imm_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_illegal  = ex_q.illegal;
    assign ex_aluop    = ex_q.aluop;
    assign ex_dmload   = ex_q.dmload;
    assign ex_dmstr    = ex_q.dmstr;
    assign ex_dmsel    = ex_q.dmsel;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_ra       = ex_q.ra;
    assign ex_rb       = ex_q.rb;
    assign ex_rw       = ex_q.rw;
    assign ex_imm      = imm_q;
    assign ex_fwd_a    = fwd_a_q;
    assign ex_fwd_b    = fwd_b_q;

endmodule

// File: tb/tb_pipelined_controller.sv
// tb_pipelined_controller: directed plan plus random instruction stream against a history-queue model
module tb_pipelined_controller;

    localparam int FWD_DEPTH = 3;
    localparam int DATA_W = 32;
    localparam int FSW = $clog2(FWD_DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst, in_valid, flush, in_ready;
    logic [DATA_W-1:0] IR;
    logic              ex_valid, ex_dmload, ex_dmstr, ex_dmsel, ex_regwrite, ex_illegal;
    logic [3:0]        ex_aluop;
    logic [4:0]        ex_ra, ex_rb, ex_rw;
    logic [DATA_W-1:0] ex_imm;
    logic [FSW-1:0]    ex_fwd_a, ex_fwd_b;

    always #5 clk = ~clk;

    pipelined_controller #(.FWD_DEPTH(FWD_DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .IR(IR), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_dmload(ex_dmload), .ex_dmstr(ex_dmstr),
        .ex_dmsel(ex_dmsel), .ex_regwrite(ex_regwrite), .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_rw(ex_rw),
        .ex_imm(ex_imm), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .ex_illegal(ex_illegal)
    );

    typedef struct {
        bit        illegal, ld, st, sel, wr, ua, ub;
        bit [3:0]  alu;
        bit [4:0]  ra, rb, rw;
        bit [31:0] imm;
    } dec_t;

    typedef struct {
        bit       en;
        bit [4:0] a;
        bit       ld;
    } wr_t;

    wr_t hist[$];
    int  n_chk = 0;
    int  n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic dec_t decode(input bit [31:0] ir);
        dec_t d;
        bit [5:0] op = ir[31:26];
        d = '{default: 0};
        d.ra = ir[25:21];
        d.rb = ir[20:16];
        d.rw = ir[20:16];
        d.ua = 1;
        d.imm = {{16{ir[15]}}, ir[15:0]};
        if (op == 6'h00) begin
            d.ub = 1;
            d.wr = 1;
            d.rw = ir[15:11];
            case (ir[5:0])
                6'h00: begin d.alu = 0; d.ua = 0; end
                6'h02: begin d.alu = 2; d.ua = 0; end
                6'h03: begin d.alu = 1; d.ua = 0; end
                6'h20, 6'h21: d.alu = 5;
                6'h22, 6'h23: d.alu = 6;
                6'h24: d.alu = 7;
                6'h25: d.alu = 8;
                6'h26: d.alu = 9;
                6'h27: d.alu = 10;
                6'h2A: d.alu = 11;
                6'h2B: d.alu = 12;
                default: d.illegal = 1;
            endcase
        end else begin
            case (op)
                6'h02: d.ua = 0;
                6'h03: begin d.ua = 0; d.wr = 1; d.rw = 31; d.alu = 5; end
                6'h04, 6'h05: begin d.ub = 1; d.alu = 6; end
                6'h08, 6'h09: begin d.wr = 1; d.alu = 5; end
                6'h0A: begin d.wr = 1; d.alu = 11; end
                6'h0B: begin d.wr = 1; d.alu = 12; end
                6'h0C: begin d.wr = 1; d.alu = 7; d.imm = {16'h0, ir[15:0]}; end
                6'h0D: begin d.wr = 1; d.alu = 8; d.imm = {16'h0, ir[15:0]}; end
                6'h0E: begin d.wr = 1; d.alu = 9; d.imm = {16'h0, ir[15:0]}; end
                6'h23: begin d.wr = 1; d.ld = 1; d.alu = 5; end
                6'h24: begin d.wr = 1; d.ld = 1; d.sel = 1; d.alu = 5; end
                6'h2B: begin d.st = 1; d.ub = 1; d.alu = 5; end
                default: d.illegal = 1;
            endcase
        end
        if (d.illegal) begin
            d.wr = 0;
            d.ld = 0;
            d.st = 0;
        end
        return d;
    endfunction

    function automatic int fwd_of(input bit [4:0] r, input bit used);
        if (!used || r == 0) return 0;
        for (int k = 0; k < FWD_DEPTH; k++)
            if (hist[k].en && hist[k].a == r) return k + 1;
        return 0;
    endfunction

    function automatic logic [63:0] gate(input bit iss, input logic [63:0] x);
        return iss ? x : 64'd0;
    endfunction

    task automatic clear_hist();
        hist.delete();
        repeat (FWD_DEPTH) hist.push_back('{0, 0, 0});
    endtask

    task automatic step(input logic [31:0] ir, input bit v, input bit fl, output bit stalled);
        dec_t d;
        bit hz, iss;
        int fa, fb;
        IR = ir;
        in_valid = v;
        flush = fl;
        #1;
        d = decode(ir);
        hz = v && hist[0].ld && hist[0].a != 0 &&
             ((d.ua && d.ra == hist[0].a) || (d.ub && d.rb == hist[0].a));
        chk("in_ready", in_ready, !(hz && !fl));
        iss = v && !fl && !hz;
        fa = iss ? fwd_of(d.ra, d.ua) : 0;
        fb = iss ? fwd_of(d.rb, d.ub) : 0;
        @(posedge clk);
        #1;
        hist.push_front('{iss && d.wr, iss ? d.rw : 5'd0, iss && d.ld});
        void'(hist.pop_back());
        chk("ex_valid", ex_valid, iss);
        chk("ex_illegal", ex_illegal, iss && d.illegal);
        chk("ex_aluop", ex_aluop, gate(iss, d.alu));
        chk("ex_dmload", ex_dmload, iss && d.ld);
        chk("ex_dmstr", ex_dmstr, iss && d.st);
        chk("ex_dmsel", ex_dmsel, iss && d.sel);
        chk("ex_regwrite", ex_regwrite, iss && d.wr);
        chk("ex_ra", ex_ra, gate(iss, d.ra));
        chk("ex_rb", ex_rb, gate(iss, d.rb));
        chk("ex_rw", ex_rw, gate(iss, d.rw));
        chk("ex_imm", ex_imm, gate(iss, d.imm));
        chk("ex_fwd_a", ex_fwd_a, 64'(fa));
        chk("ex_fwd_b", ex_fwd_b, 64'(fb));
        stalled = hz && !fl;
    endtask

    task automatic issue(input logic [31:0] ir);
        bit s;
        int n = 0;
        do begin
            step(ir, 1'b1, 1'b0, s);
            n++;
        end while (s && n < 3);
        chk("stall_len", n <= 2, 1);
    endtask

    function automatic logic [31:0] rand_ir();
        logic [5:0] ops [16] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h24, 6'h2B, 6'h3F};
        logic [5:0] fns [14] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                                 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};
        logic [31:0] ir;
        ir = {ops[$urandom_range(0, 15)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
        if (ir[31:26] == 6'h00) begin
            ir[15:11] = 5'($urandom_range(0, 3));
            ir[5:0] = fns[$urandom_range(0, 13)];
        end
        return ir;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit s;
        logic [31:0] ir;
        rst = 1'b1;
        in_valid = 1'b1;
        flush = 1'b0;
        IR = 32'h00652020;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_aluop", ex_aluop, 0);
        chk("rst_regwrite", ex_regwrite, 0);
        chk("rst_rw", ex_rw, 0);
        chk("rst_imm", ex_imm, 0);
        chk("rst_fwd", {ex_fwd_a, ex_fwd_b}, 0);
        rst = 1'b0;
        clear_hist();
        #1;
        chk("rst_ready", in_ready, 1);

        issue(32'h8C430004);
        chk("lw_valid", ex_valid, 1);
        chk("lw_alu", ex_aluop, 5);
        chk("lw_load", ex_dmload, 1);
        chk("lw_rw", ex_rw, 3);
        chk("lw_wr", ex_regwrite, 1);
        chk("lw_imm", ex_imm, 32'h4);
        issue(32'hAC430004);
        chk("sw_str", ex_dmstr, 1);
        chk("sw_wr", ex_regwrite, 0);

        step(32'h8C430004, 1'b1, 1'b0, s);
        step(32'h00652020, 1'b1, 1'b0, s);
        chk("lu_stall", s, 1);
        chk("lu_bubble", ex_valid, 0);
        step(32'h00652020, 1'b1, 1'b0, s);
        chk("lu_issue", ex_valid, 1);
        chk("lu_fwd_a", ex_fwd_a, 2);
        chk("lu_fwd_b", ex_fwd_b, 0);

        issue(32'h20010001);
        issue(32'h20210001);
        issue(32'h00211020);
        chk("prio_a", ex_fwd_a, 1);
        chk("prio_b", ex_fwd_b, 1);
        issue(32'h20000005);
        issue(32'h00003020);
        chk("r0_a", ex_fwd_a, 0);
        chk("r0_b", ex_fwd_b, 0);

        step(32'h8C430004, 1'b1, 1'b0, s);
        step(32'h00652020, 1'b1, 1'b1, s);
        chk("fl_nostall", s, 0);
        chk("fl_bubble", ex_valid, 0);
        issue(32'h00E84820);
        chk("fl_fwd_a", ex_fwd_a, 0);
        chk("fl_fwd_b", ex_fwd_b, 0);

        issue(32'hFC000000);
        chk("ill_valid", ex_valid, 1);
        chk("ill_flag", ex_illegal, 1);
        chk("ill_wr", ex_regwrite, 0);
        chk("ill_str", ex_dmstr, 0);
        issue(32'hFC1F0000);
        issue(32'h03E00820);
        chk("ill_fwd", ex_fwd_a, 0);

        ir = rand_ir();
        for (int i = 0; i < 400; i++) begin
            step(ir, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, s);
            if (!s) ir = rand_ir();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
